// File: rtl/nibble_add_pkg.sv
// Shared definitions for the nibble-serial adder controller.
//   state_t   : controller FSM encoding (IDLE, RUN, DONE)
//   NIB_W     : width of the adder slice in bits
//   idx_w()   : width of the nibble index counter, clog2(n) but at least 1
package nibble_add_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/nibble_add_slice.sv
// Purely combinational 4-bit ripple-carry adder slice.
// Ports:
//   a, b : 4-bit addends
//   cin  : carry into bit 0
//   s    : 4-bit sum
//   cout : carry out of bit 3
module nibble_add_slice
  import nibble_add_pkg::*;
(
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] b,
  input  logic             cin,
  output logic [NIB_W-1:0] s,
  output logic             cout
);

  // w_c[i] is the carry into bit i; w_c[NIB_W] is the slice carry-out.
  logic [NIB_W:0] w_c;

  assign w_c[0] = cin;

  for (genvar i = 0; i < NIB_W; i++) begin : g_fa
    assign s[i]     = a[i] ^ b[i] ^ w_c[i];
    assign w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
  end

  assign cout = w_c[NIB_W];

endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// WIDTH-bit adder that reuses one 4-bit slice over WIDTH/4 cycles,
// least-significant nibble first, with a registered carry between nibbles.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   start_valid  : requester offers a, b, cin
//   start_ready  : controller idle and able to accept
//   a, b, cin    : operands, sampled only on accept
//   sum, cout    : registered result, held until the next operation starts
//   done_valid   : result available
//   done_ready   : consumer takes the result
//   busy         : operation in progress or result pending
//   nib_idx      : nibble being added this cycle (debug)
//   dbg_state    : FSM state encoding (debug)
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high. start_ready is high exactly in IDLE; done_valid is high exactly
// in DONE and stays high, with sum/cout stable, until done_ready is seen.
// start_valid outside IDLE and done_ready outside DONE are ignored.
//
// WIDTH must be a multiple of 4 and at least 4.
module nibble_serial_add_ctrl
  import nibble_add_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start_valid,
  output logic                         start_ready,
  input  logic [WIDTH-1:0]             a,
  input  logic [WIDTH-1:0]             b,
  input  logic                         cin,
  output logic [WIDTH-1:0]             sum,
  output logic                         cout,
  output logic                         done_valid,
  input  logic                         done_ready,
  output logic                         busy,
  output logic [idx_w(WIDTH/4)-1:0]    nib_idx,
  output logic [1:0]                   dbg_state
);

  localparam int NIB  = WIDTH / NIB_W;
  localparam int IDXW = idx_w(NIB);

  state_t            r_state;
  logic [WIDTH-1:0]  r_op_a;
  logic [WIDTH-1:0]  r_op_b;
  logic              r_carry;
  logic [WIDTH-1:0]  r_sum;
  logic              r_cout;
  logic              r_done_valid;
  logic              r_busy;
  logic [IDXW-1:0]   r_nib_idx;

  logic [NIB_W-1:0]  w_slice_s;
  logic              w_slice_co;
  logic [WIDTH-1:0]  w_sum_shift;
  logic              w_last;

  nibble_add_slice u_slice (
    .a    (r_op_a[NIB_W-1:0]),
    .b    (r_op_b[NIB_W-1:0]),
    .cin  (r_carry),
    .s    (w_slice_s),
    .cout (w_slice_co)
  );

  // New nibble enters at the MSB end; after NIB steps the first nibble has
  // walked down to bits [3:0], so the result lands already aligned.
  if (NIB == 1) begin : g_one_nib
    assign w_sum_shift = w_slice_s;
  end else begin : g_multi_nib
    assign w_sum_shift = {w_slice_s, r_sum[WIDTH-1:NIB_W]};
  end

  assign w_last = (r_nib_idx == IDXW'(NIB - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_op_a       <= '0;
      r_op_b       <= '0;
      r_carry      <= 1'b0;
      r_sum        <= '0;
      r_cout       <= 1'b0;
      r_done_valid <= 1'b0;
      r_busy       <= 1'b0;
      r_nib_idx    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start_valid) begin
            r_op_a    <= a;
            r_op_b    <= b;
            r_carry   <= cin;
            r_nib_idx <= '0;
            r_busy    <= 1'b1;
            r_state   <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_sum   <= w_sum_shift;
          r_op_a  <= r_op_a >> NIB_W;
          r_op_b  <= r_op_b >> NIB_W;
          r_carry <= w_slice_co;
          if (w_last) begin
            // Index parks at 0 so DONE/IDLE always show a clean value.
            r_cout       <= w_slice_co;
            r_nib_idx    <= '0;
            r_done_valid <= 1'b1;
            r_state      <= ST_DONE;
          end else begin
            r_nib_idx <= r_nib_idx + IDXW'(1);
          end
        end
        ST_DONE: begin
          if (done_ready) begin
            r_done_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_state      <= ST_IDLE;
          end
        end
        default: begin
          r_state      <= ST_IDLE;
          r_done_valid <= 1'b0;
          r_busy       <= 1'b0;
        end
      endcase
    end
  end

  assign start_ready = (r_state == ST_IDLE);
  assign sum         = r_sum;
  assign cout        = r_cout;
  assign done_valid  = r_done_valid;
  assign busy        = r_busy;
  assign nib_idx     = r_nib_idx;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
module tb_nibble_serial_add_ctrl;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // WIDTH=16 instance
  logic        sv16, sr16, cin16, co16, dv16, dr16, busy16;
  logic [15:0] a16, b16, sum16;
  logic [1:0]  idx16;
  logic [1:0]  st16;

  // WIDTH=4 instance
  logic        sv4, sr4, cin4, co4, dv4, dr4, busy4;
  logic [3:0]  a4, b4, sum4;
  logic [0:0]  idx4;
  logic [1:0]  st4;

  nibble_serial_add_ctrl #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .start_valid(sv16), .start_ready(sr16),
    .a(a16), .b(b16), .cin(cin16), .sum(sum16), .cout(co16),
    .done_valid(dv16), .done_ready(dr16), .busy(busy16),
    .nib_idx(idx16), .dbg_state(st16)
  );

  nibble_serial_add_ctrl #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start_valid(sv4), .start_ready(sr4),
    .a(a4), .b(b4), .cin(cin4), .sum(sum4), .cout(co4),
    .done_valid(dv4), .done_ready(dr4), .busy(busy4),
    .nib_idx(idx4), .dbg_state(st4)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver tasks (WIDTH=16) ----------------
  task automatic start16(input string tag, input logic [15:0] a, input logic [15:0] b, input logic c);
    check({tag, "_ready_before_accept"}, {31'd0, sr16}, 32'd1);
    sv16 = 1'b1; a16 = a; b16 = b; cin16 = c;
    tick();
    sv16 = 1'b0;
    // Operands are free to change once accepted.
    a16 = $urandom_range(0, 65535); b16 = $urandom_range(0, 65535); cin16 = ~c;
    check({tag, "_busy_after_accept"}, {31'd0, busy16}, 32'd1);
  endtask

  task automatic wait_done16(input string tag);
    int n;
    n = 0;
    while (!dv16 && n < 20) begin
      check({tag, "_nib_idx"}, {30'd0, idx16}, n);
      check({tag, "_ready_low_in_run"}, {31'd0, sr16}, 32'd0);
      tick();
      n++;
    end
    check({tag, "_latency"}, n, 32'd4);
  endtask

  task automatic result16(input string tag, input logic [15:0] es, input logic ec);
    check({tag, "_sum"}, {16'd0, sum16}, {16'd0, es});
    check({tag, "_cout"}, {31'd0, co16}, {31'd0, ec});
    check({tag, "_ready_low_in_done"}, {31'd0, sr16}, 32'd0);
  endtask

  task automatic finish16(input string tag, input logic [15:0] es, input logic ec);
    dr16 = 1'b1;
    tick();
    dr16 = 1'b0;
    check({tag, "_done_valid_cleared"}, {31'd0, dv16}, 32'd0);
    check({tag, "_ready_back"}, {31'd0, sr16}, 32'd1);
    check({tag, "_busy_cleared"}, {31'd0, busy16}, 32'd0);
    check({tag, "_sum_retained"}, {16'd0, sum16}, {16'd0, es});
    check({tag, "_cout_retained"}, {31'd0, co16}, {31'd0, ec});
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] exp_sum;
    logic        exp_cout;
  } vec_t;

  vec_t vecs[9];

  initial begin
    vecs[0] = '{a: 16'hFFFF, b: 16'h0001, cin: 1'b0, exp_sum: 16'h0000, exp_cout: 1'b1};
    vecs[1] = '{a: 16'h1234, b: 16'h4321, cin: 1'b1, exp_sum: 16'h5556, exp_cout: 1'b0};
    vecs[2] = '{a: 16'h8000, b: 16'h8000, cin: 1'b0, exp_sum: 16'h0000, exp_cout: 1'b1};
    vecs[3] = '{a: 16'h0000, b: 16'h0000, cin: 1'b0, exp_sum: 16'h0000, exp_cout: 1'b0};
    vecs[4] = '{a: 16'hFFFF, b: 16'hFFFF, cin: 1'b1, exp_sum: 16'hFFFF, exp_cout: 1'b1};
    vecs[5] = '{a: 16'h0FFF, b: 16'h0001, cin: 1'b0, exp_sum: 16'h1000, exp_cout: 1'b0};
    vecs[6] = '{a: 16'hF0F0, b: 16'h0F0F, cin: 1'b1, exp_sum: 16'h0000, exp_cout: 1'b1};
    vecs[7] = '{a: 16'h7FFF, b: 16'h0000, cin: 1'b1, exp_sum: 16'h8000, exp_cout: 1'b0};
    vecs[8] = '{a: 16'hABCD, b: 16'h1111, cin: 1'b0, exp_sum: 16'hBCDE, exp_cout: 1'b0};

    sv16 = 0; a16 = 0; b16 = 0; cin16 = 0; dr16 = 0;
    sv4 = 0; a4 = 0; b4 = 0; cin4 = 0; dr4 = 0;

    // Reset and reset values
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("rst_start_ready", {31'd0, sr16}, 32'd1);
    check("rst_done_valid", {31'd0, dv16}, 32'd0);
    check("rst_busy", {31'd0, busy16}, 32'd0);
    check("rst_sum", {16'd0, sum16}, 32'd0);
    check("rst_cout", {31'd0, co16}, 32'd0);
    check("rst_nib_idx", {30'd0, idx16}, 32'd0);
    check("rst_state", {30'd0, st16}, 32'd0);
    check("rst4_sum", {28'd0, sum4}, 32'd0);

    // Table-driven operations, zero backpressure
    for (int i = 0; i < 9; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      start16(tag, vecs[i].a, vecs[i].b, vecs[i].cin);
      wait_done16(tag);
      result16(tag, vecs[i].exp_sum, vecs[i].exp_cout);
      finish16(tag, vecs[i].exp_sum, vecs[i].exp_cout);
    end

    // Backpressure: hold the consumer off for 3 cycles
    start16("bp", 16'h8000, 16'h8000, 1'b0);
    wait_done16("bp");
    for (int k = 0; k < 3; k++) begin
      result16("bp_hold", 16'h0000, 1'b1);
      check("bp_hold_done_valid", {31'd0, dv16}, 32'd1);
      tick();
    end
    check("bp_still_valid", {31'd0, dv16}, 32'd1);
    finish16("bp", 16'h0000, 1'b1);

    // start_valid held with new operands through RUN and DONE
    start16("spam", 16'h1111, 16'h2222, 1'b0);
    sv16 = 1'b1; a16 = 16'h0F00; b16 = 16'h0100; cin16 = 1'b1;
    wait_done16("spam");
    result16("spam", 16'h3333, 1'b0);
    tick();
    result16("spam_hold", 16'h3333, 1'b0);
    finish16("spam", 16'h3333, 1'b0);
    // Still requesting in IDLE: accepted on this edge.
    tick();
    sv16 = 1'b0;
    check("spam2_accepted", {31'd0, busy16}, 32'd1);
    wait_done16("spam2");
    result16("spam2", 16'h1001, 1'b0);
    finish16("spam2", 16'h1001, 1'b0);

    // Reset mid-RUN at nib_idx==2
    begin
      logic seen_dv;
      start16("abort", 16'h5555, 16'h5555, 1'b0);
      tick();
      tick();
      check("abort_idx_before_rst", {30'd0, idx16}, 32'd2);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("abort_state", {30'd0, st16}, 32'd0);
      check("abort_ready", {31'd0, sr16}, 32'd1);
      check("abort_busy", {31'd0, busy16}, 32'd0);
      check("abort_sum", {16'd0, sum16}, 32'd0);
      check("abort_cout", {31'd0, co16}, 32'd0);
      check("abort_nib_idx", {30'd0, idx16}, 32'd0);
      seen_dv = dv16;
      for (int k = 0; k < 6; k++) begin
        tick();
        seen_dv = seen_dv | dv16;
      end
      check("abort_no_done_valid", {31'd0, seen_dv}, 32'd0);
      start16("fresh", 16'h00FF, 16'h0F01, 1'b0);
      wait_done16("fresh");
      result16("fresh", 16'h1000, 1'b0);
      finish16("fresh", 16'h1000, 1'b0);
    end

    // WIDTH=4 instance: single RUN cycle
    begin
      int n;
      check("w4_ready", {31'd0, sr4}, 32'd1);
      sv4 = 1'b1; a4 = 4'hF; b4 = 4'hF; cin4 = 1'b1;
      tick();
      sv4 = 1'b0; a4 = 4'h0; b4 = 4'h0; cin4 = 1'b0;
      check("w4_run_busy", {31'd0, busy4}, 32'd1);
      check("w4_run_idx", {31'd0, idx4}, 32'd0);
      check("w4_run_not_done", {31'd0, dv4}, 32'd0);
      n = 0;
      while (!dv4 && n < 10) begin
        tick();
        n++;
      end
      check("w4_latency", n, 32'd1);
      check("w4_sum", {28'd0, sum4}, 32'hF);
      check("w4_cout", {31'd0, co4}, 32'd1);
      dr4 = 1'b1;
      tick();
      dr4 = 1'b0;
      check("w4_done_cleared", {31'd0, dv4}, 32'd0);
      check("w4_ready_back", {31'd0, sr4}, 32'd1);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
